// File: rtl/vehicle_gate_ctrl.sv
// Gate/speed-trap control FSM: sensor conditioning, transit timing,
// barrier sequencing, exit down-count and overspeed/fault flags.
module vehicle_gate_ctrl #(
  parameter int DEB_CYCLES  = 50000,
  parameter int MIN_CYC     = 50000,
  parameter int TIMEOUT_CYC = 25000000,
  parameter int HOLD_CYC    = 100000000,
  parameter int SPEED_LIMIT = 60,
  parameter int MAX_VEH     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sensor_a,
  input  logic        sensor_b,
  input  logic        sensor_x,
  input  logic        manual_open,
  input  logic [1:0]  num_veh,
  input  logic [13:0] speed,
  input  logic        done,
  output logic        init,
  output logic        count,
  output logic        cal,
  output logic        up,
  output logic        down,
  output logic        en,
  output logic        dis,
  output logic        full,
  output logic        overspeed,
  output logic        fault
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_TIMING, S_CALC,
    S_WAIT, S_OPEN, S_HOLD, S_ABORT
  } state_t;

  logic [2:0]    r_sync1, r_sync2;
  logic [2:0]    r_deb, r_deb_d, r_rise;
  logic [DW-1:0] r_dcnt [3];

  state_t        r_state, w_next;
  logic [TW-1:0] r_tcnt;
  logic [HW-1:0] r_hcnt;
  logic          r_down_pend;

  logic r_init, r_count, r_cal, r_up;
  logic r_down, r_en, r_dis, r_ovs, r_fault;

  logic w_a_rise, w_b_rise, w_x_rise;
  logic w_full, w_en, w_dis, w_set, w_fire;

  assign w_a_rise = r_rise[0];
  assign w_b_rise = r_rise[1];
  assign w_x_rise = r_rise[2];
  assign w_full   = (num_veh == 2'(MAX_VEH));

  // Level flips only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_rise  <= '0;
      for (int i = 0; i < 3; i++) r_dcnt[i] <= '0;
    end else begin
      r_sync1 <= {sensor_x, sensor_b, sensor_a};
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      r_rise  <= r_deb & ~r_deb_d;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DW'(DEB_CYCLES - 1)) begin
          r_deb[i]  <= r_sync2[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_en   = 1'b0;
    w_dis  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_a_rise && !w_full) begin
          w_next = S_START;
        end else if (manual_open) begin
          w_next = S_HOLD;
          w_en   = 1'b1;
        end
      end
      S_START: w_next = S_TIMING;
      S_TIMING: begin
        if (w_b_rise)
          w_next = (r_tcnt >= TW'(MIN_CYC)) ? S_CALC : S_ABORT;
        else if (r_tcnt >= TW'(TIMEOUT_CYC))
          w_next = S_ABORT;
      end
      S_CALC: w_next = S_WAIT;
      S_WAIT: if (done) w_next = S_OPEN;
      S_OPEN: w_next = S_HOLD;
      S_HOLD: begin
        // dis is registered, so it is requested one count early
        if (r_hcnt == HW'(HOLD_CYC - 1))
          w_next = S_IDLE;
        else if (!manual_open && r_hcnt == HW'(HOLD_CYC - 2))
          w_dis = 1'b1;
      end
      S_ABORT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_set  = w_x_rise && (num_veh != 2'd0);
  assign w_fire = (r_down_pend || w_set) && (w_next != S_OPEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tcnt      <= '0;
      r_hcnt      <= '0;
      r_down_pend <= 1'b0;
      r_init      <= 1'b0;
      r_count     <= 1'b0;
      r_cal       <= 1'b0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_en        <= 1'b0;
      r_dis       <= 1'b0;
      r_ovs       <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_START)
        r_tcnt <= '0;
      else if (r_state == S_TIMING && r_tcnt != TW'(TIMEOUT_CYC))
        r_tcnt <= r_tcnt + 1'b1;
      if (r_state != S_HOLD || manual_open)
        r_hcnt <= '0;
      else
        r_hcnt <= r_hcnt + 1'b1;
      r_down_pend <= (r_down_pend || w_set) && !w_fire;
      r_init  <= (w_next == S_START) || (w_next == S_ABORT);
      r_count <= (w_next == S_TIMING);
      r_cal   <= (w_next == S_CALC);
      r_up    <= (w_next == S_OPEN);
      r_fault <= (w_next == S_ABORT);
      r_down  <= w_fire;
      r_en    <= w_en;
      r_dis   <= w_dis;
      if (r_state == S_WAIT && done)
        r_ovs <= (speed > 14'(SPEED_LIMIT));
    end
  end

  assign init      = r_init;
  assign count     = r_count;
  assign cal       = r_cal;
  assign up        = r_up;
  assign down      = r_down;
  assign en        = r_en;
  assign dis       = r_dis;
  assign full      = w_full;
  assign overspeed = r_ovs;
  assign fault     = r_fault;

endmodule

// File: tb/tb_vehicle_gate_ctrl.sv
// Scoreboard bench for vehicle_gate_ctrl: expected strobe events are
// queued by the stimulus and matched by a negedge monitor.
module tb_vehicle_gate_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sensor_a = 1'b0, sensor_b = 1'b0, sensor_x = 1'b0;
  logic        manual_open = 1'b0;
  logic [1:0]  num_veh = 2'd0;
  logic [13:0] speed = '0;
  logic        done = 1'b0;
  logic        init, count, cal, up, down, en, dis;
  logic        full, overspeed, fault;

  vehicle_gate_ctrl #(
    .DEB_CYCLES(4), .MIN_CYC(10), .TIMEOUT_CYC(100),
    .HOLD_CYC(20), .SPEED_LIMIT(60), .MAX_VEH(3)
  ) dut (
    .clk(clk), .reset(reset),
    .sensor_a(sensor_a), .sensor_b(sensor_b), .sensor_x(sensor_x),
    .manual_open(manual_open), .num_veh(num_veh),
    .speed(speed), .done(done),
    .init(init), .count(count), .cal(cal), .up(up),
    .down(down), .en(en), .dis(dis), .full(full),
    .overspeed(overspeed), .fault(fault)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] INIT = 8'h01, CNT = 8'h02, CAL = 8'h04;
  localparam logic [7:0] UP = 8'h08, DN = 8'h10, EN = 8'h20;
  localparam logic [7:0] DIS = 8'h40, FLT = 8'h80;

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic push(input int c, input logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.v = v;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [7:0] v;
    exp_t e;
    v = {fault, dis, en, down, up, cal, count, init};
    if (mon_en && v != 8'h00) begin
      n_chk++;
      if (q.size() == 0) begin
        $display("FAIL strobe: unexpected v=%h at cycle %0d", v, cyc);
      end else begin
        e = q.pop_front();
        if (e.cyc == cyc && e.v == v) n_pass++;
        else $display("FAIL strobe: got v=%h @%0d want v=%h @%0d",
                      v, cyc, e.v, e.cyc);
      end
    end
  end

  // One vehicle through the trap; optional exit collision and reset in HOLD
  task automatic car(input int b_off, input logic [13:0] spd,
                     input bit coll, input bit rst_mid);
    int n;
    n = cyc;
    sensor_a = 1'b1;
    push(n + 8, INIT);
    for (int k = n + 9; k <= n + b_off + 7; k++) push(k, CNT);
    push(n + b_off + 8, CAL);
    push(n + b_off + 11, UP);
    if (coll) push(n + b_off + 12, DN);
    if (!rst_mid) push(n + b_off + 31, DIS);
    goto(n + b_off);
    sensor_b = 1'b1;
    if (coll) begin
      goto(n + b_off + 4);
      sensor_x = 1'b1;
    end
    goto(n + b_off + 10);
    done = 1'b1;
    speed = spd;
    goto(n + b_off + 11);
    done = 1'b0;
    goto(n + b_off + 12);
    chk("overspeed", int'(overspeed), (spd > 14'd60) ? 1 : 0);
    goto(n + b_off + 15);
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    sensor_x = 1'b0;
    if (rst_mid) begin
      goto(n + b_off + 20);
      reset = 1'b1;
      goto(n + b_off + 21);
      reset = 1'b0;
      chk("rst_outs",
          int'({fault, dis, en, down, up, cal, count, init, overspeed}), 0);
      goto(n + b_off + 40);
    end else begin
      goto(n + b_off + 45);
    end
  endtask

  initial begin
    int n;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_outs",
        int'({fault, dis, en, down, up, cal, count, init, overspeed}), 0);
    chk("reset_full", int'(full), 0);
    mon_en = 1'b1;

    // Normal run, overspeed
    num_veh = 2'd1;
    car(40, 14'd80, 1'b0, 1'b0);

    // 3-cycle glitch on A: nothing
    n = cyc;
    sensor_a = 1'b1;
    goto(n + 3);
    sensor_a = 1'b0;
    goto(n + 25);

    // Normal run under the limit
    car(40, 14'd50, 1'b0, 1'b0);

    // Short transit: abort
    n = cyc;
    sensor_a = 1'b1;
    push(n + 8, INIT);
    for (int k = n + 9; k <= n + 12; k++) push(k, CNT);
    push(n + 13, INIT | FLT);
    goto(n + 5);
    sensor_b = 1'b1;
    goto(n + 20);
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    goto(n + 40);

    // No B: timeout abort
    n = cyc;
    sensor_a = 1'b1;
    push(n + 8, INIT);
    for (int k = n + 9; k <= n + 109; k++) push(k, CNT);
    push(n + 110, INIT | FLT);
    goto(n + 20);
    sensor_a = 1'b0;
    goto(n + 130);

    // Full lot: A ignored, exit still counts down
    n = cyc;
    num_veh = 2'd3;
    #1;
    chk("full_at_3", int'(full), 1);
    sensor_a = 1'b1;
    push(n + 28, DN);
    goto(n + 10);
    sensor_a = 1'b0;
    goto(n + 20);
    sensor_x = 1'b1;
    goto(n + 25);
    sensor_x = 1'b0;
    goto(n + 45);
    num_veh = 2'd2;
    #1;
    chk("full_at_2", int'(full), 0);

    // Exit with empty lot is dropped
    n = cyc;
    num_veh = 2'd0;
    sensor_x = 1'b1;
    goto(n + 10);
    sensor_x = 1'b0;
    goto(n + 25);

    // Exit rise on the OPEN cycle
    num_veh = 2'd1;
    car(40, 14'd60, 1'b1, 1'b0);

    // Reset during HOLD: no dis
    car(40, 14'd80, 1'b0, 1'b1);

    // Manual open from IDLE, then extend in HOLD
    n = cyc;
    push(n + 1, EN);
    push(n + 30, DIS);
    manual_open = 1'b1;
    goto(n + 1);
    manual_open = 1'b0;
    goto(n + 10);
    manual_open = 1'b1;
    goto(n + 11);
    manual_open = 1'b0;
    goto(n + 45);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      $display("FAIL missing strobe: v=%h @%0d", e.v, e.cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
